bsg_manycore_link_sif_trap: RTL and testbench
=============================================

Name: bsg_manycore_link_sif_trap

Overview:
Parametrised, stateful successor to the plain link_sif tie-off used on unused mesh edges (W/E/N/S/io).
- Terminates num_ch_p forward links.
- Accepts every stray request and, in respond mode, returns a well-formed response so a misrouted load cannot hang the sender.
- Counts strays per channel and captures the first offender for host debug.
- Instanced in the manycore wrapper in place of per-edge tie-offs.

Parameters:
num_ch_p, 4, number of terminated channels
x_cord_width_p, 4, x coordinate width
y_cord_width_p, 3, y coordinate width
load_id_width_p, 5, load id width
data_width_p, 32, response data width
els_p, 2, per-channel response FIFO depth (>=2)
count_width_p, 16, per-channel stray counter width
load_pattern_p, 32'hDEAD_BEEF, data returned for trapped loads/AMOs

Ports:
clk_i  in  1  clock
reset_n_i  in  1  async active-low reset
respond_en_i  in  1  1=generate responses, 0=accept and drop
clear_i  in  1  sync clear of counters and capture (FIFOs untouched)
fwd_v_i  in  num_ch_p  request valid
fwd_op_i  in  num_ch_p*2  op: 0 load, 1 store, 2 amo, 3 reserved
fwd_src_x_i  in  num_ch_p*x_cord_width_p  requester x
fwd_src_y_i  in  num_ch_p*y_cord_width_p  requester y
fwd_load_id_i  in  num_ch_p*load_id_width_p  request load id
fwd_ready_o  out  num_ch_p  request accept
rev_v_o  out  num_ch_p  response valid
rev_type_o  out  num_ch_p  1=load data, 0=store ack
rev_data_o  out  num_ch_p*data_width_p  response data
rev_load_id_o  out  num_ch_p*load_id_width_p  echoed load id
rev_dst_x_o  out  num_ch_p*x_cord_width_p  = requester x
rev_dst_y_o  out  num_ch_p*y_cord_width_p  = requester y
rev_ready_i  in  num_ch_p  response consumed
count_o  out  num_ch_p*count_width_p  per-channel stray count
stray_o  out  1  sticky: any stray since reset/clear
first_ch_o  out  clog2(num_ch_p)  channel of first stray
first_x_o  out  x_cord_width_p  src x of first stray
first_y_o  out  y_cord_width_p  src y of first stray

Behaviour:
- Reset (reset_n_i low, async): all FIFOs empty, counters 0, stray_o/first_* 0, rev_v_o 0.
- fwd_ready_o[c]:
  - respond_en_i=0: 1 (out of reset).
  - respond_en_i=1: !full[c]. A same-cycle pop does not free a slot for that cycle's accept.
- Accept on c: fwd_v_i[c] & fwd_ready_o[c].
- Accept with respond_en_i=1 pushes one entry into FIFO c:
  - op 0 or 2: type=1, data=load_pattern_p.
  - op 1: type=0, data=0.
  - op 3: no push; counted only.
  - load_id and dst x/y copied from the request.
- Rev: rev_v_o[c]=!empty[c]; head fields on rev_* outputs; pop on rev_v_o & rev_ready_i.
- Latency: response visible the cycle after acceptance. No bypass.
- Order: per-channel FIFO order. Channels are fully independent.
- Changing respond_en_i never drops or alters queued entries; they drain normally.
- Counter c: +1 per accept (any op, any mode), saturating at all-ones (no wrap).
- Capture: when stray_o=0 and at least one accept occurs, on the next edge:
  - stray_o<=1.
  - first_* loaded from the lowest-index accepting channel.
  - Held until clear_i or reset.
- clear_i:
  - Next edge: counters 0, stray_o 0, first_* 0.
  - Accept in the same cycle wins: that counter becomes 1, and stray_o/first_* are captured from that accept.
- Reset asserted mid-transaction discards queued responses immediately. No partial packets are emitted.

Test Plan:
- Reset, respond_en_i=1, ch1 load src(3,2) id 5, rev_ready_i=1 -> next cycle rev_v_o[1]=1, type 1, data 0xDEADBEEF, id 5, dst (3,2); count_o[1]=1; stray_o=1, first_ch_o=1.
- Ch0: 3 back-to-back stores, rev_ready_i[0]=0, els_p=2 -> 2 accepted, fwd_ready_o[0]=0 on 3rd; release ready -> 2 acks (type 0, data 0) in order, then 3rd accepted.
- Same cycle ch2 and ch3 accept, stray_o=0 -> first_ch_o=2; count_o[2]=count_o[3]=1.
- respond_en_i=0, 10 loads on ch0 -> all accepted with ready=1, no rev_v_o, count_o[0]=10. Op 3 with respond_en_i=1 -> counted, no response.
- count_width_p=4: 20 accepts -> count_o holds 15. clear_i together with 1 accept -> count 1, stray_o stays 1.
- Queue 2 responses, assert reset_n_i low mid-drain -> rev_v_o drops to 0 immediately, all outputs 0 after release.

Source files
------------

// File: rtl/bsg_manycore_link_sif_trap.sv
// Stateful terminator for unused manycore mesh edges.
// Every request arriving on a terminated channel is accepted. In respond mode
// a well-formed response is queued per channel so a misrouted load cannot
// hang its sender. Strays are counted per channel, and the first offender is
// captured for host debug.
module bsg_manycore_link_sif_trap #(
    parameter int num_ch_p        = 4,
    parameter int x_cord_width_p  = 4,
    parameter int y_cord_width_p  = 3,
    parameter int load_id_width_p = 5,
    parameter int data_width_p    = 32,
    parameter int els_p           = 2,
    parameter int count_width_p   = 16,
    parameter logic [data_width_p-1:0] load_pattern_p = data_width_p'(32'hDEAD_BEEF)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   respond_en_i,
    input  logic                                   clear_i,
    input  logic [num_ch_p-1:0]                    fwd_v_i,
    input  logic [num_ch_p*2-1:0]                  fwd_op_i,
    input  logic [num_ch_p*x_cord_width_p-1:0]     fwd_src_x_i,
    input  logic [num_ch_p*y_cord_width_p-1:0]     fwd_src_y_i,
    input  logic [num_ch_p*load_id_width_p-1:0]    fwd_load_id_i,
    output logic [num_ch_p-1:0]                    fwd_ready_o,
    output logic [num_ch_p-1:0]                    rev_v_o,
    output logic [num_ch_p-1:0]                    rev_type_o,
    output logic [num_ch_p*data_width_p-1:0]       rev_data_o,
    output logic [num_ch_p*load_id_width_p-1:0]    rev_load_id_o,
    output logic [num_ch_p*x_cord_width_p-1:0]     rev_dst_x_o,
    output logic [num_ch_p*y_cord_width_p-1:0]     rev_dst_y_o,
    input  logic [num_ch_p-1:0]                    rev_ready_i,
    output logic [num_ch_p*count_width_p-1:0]      count_o,
    output logic                                   stray_o,
    output logic [((num_ch_p > 1) ? $clog2(num_ch_p) : 1)-1:0] first_ch_o,
    output logic [x_cord_width_p-1:0]              first_x_o,
    output logic [y_cord_width_p-1:0]              first_y_o
);

    localparam int CH_W  = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
    localparam int PTR_W = $clog2(els_p);
    localparam int CNT_W = $clog2(els_p + 1);
    // Queue entry layout, MSB first: type, data, load id, dst x, dst y.
    localparam int ENT_W = 1 + data_width_p + load_id_width_p + x_cord_width_p + y_cord_width_p;

    // Saturating increment: a stray counter sticks at all-ones instead of wrapping.
    function automatic logic [count_width_p-1:0] sat_inc(input logic [count_width_p-1:0] v);
        return (&v) ? v : v + count_width_p'(1);
    endfunction

    // Circular pointer advance for a depth that need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(els_p - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [num_ch_p-1:0] acc;

    for (genvar c = 0; c < num_ch_p; c++) begin : g_ch
        logic [1:0]               op;
        logic                     full, empty, push, pop;
        logic [ENT_W-1:0]         entry_in, head;
        logic [ENT_W-1:0]         mem_q [els_p];
        logic [PTR_W-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
        logic [CNT_W-1:0]         fill_q, fill_d;
        logic [count_width_p-1:0] cnt_q, cnt_d;

        assign op    = fwd_op_i[2*c +: 2];
        assign full  = (fill_q == CNT_W'(els_p));
        assign empty = (fill_q == '0);

        // Fullness comes from the registered fill level, so a pop in the
        // same cycle never opens a slot for that cycle's accept.
        assign fwd_ready_o[c] = respond_en_i ? !full : 1'b1;
        assign acc[c]         = fwd_v_i[c] & fwd_ready_o[c];
        assign push           = acc[c] & respond_en_i & (op != 2'd3);
        assign pop            = !empty & rev_ready_i[c];

        // Loads and AMOs (op 0/2) return the pattern; stores (op 1) get a zero-data ack.
        assign entry_in = {~op[0],
                           (op == 2'd1) ? {data_width_p{1'b0}} : load_pattern_p,
                           fwd_load_id_i[c*load_id_width_p +: load_id_width_p],
                           fwd_src_x_i[c*x_cord_width_p +: x_cord_width_p],
                           fwd_src_y_i[c*y_cord_width_p +: y_cord_width_p]};

        // Response storage; contents are don't-care while not queued, so no reset.
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wptr_q] <= entry_in;
            end
        end

        // Next-state of the queue pointers, fill level and stray counter.
        always_comb begin
            wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
            rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
            fill_d = fill_q;
            if (push && !pop) begin
                fill_d = fill_q + CNT_W'(1);
            end else if (!push && pop) begin
                fill_d = fill_q - CNT_W'(1);
            end
            // An accept coincident with clear still counts, from zero.
            if (clear_i) begin
                cnt_d = acc[c] ? count_width_p'(1) : '0;
            end else begin
                cnt_d = acc[c] ? sat_inc(cnt_q) : cnt_q;
            end
        end

        // Queue control and counter registers; reset empties the queue at once.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                fill_q <= '0;
                cnt_q  <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                fill_q <= fill_d;
                cnt_q  <= cnt_d;
            end
        end

        // Head fields are forced to zero while empty so nothing stale leaks out.
        assign head = mem_q[rptr_q];
        assign rev_v_o[c]    = !empty;
        assign rev_type_o[c] = !empty & head[ENT_W-1];
        assign rev_data_o[c*data_width_p +: data_width_p] =
            empty ? '0 : head[ENT_W-2 -: data_width_p];
        assign rev_load_id_o[c*load_id_width_p +: load_id_width_p] =
            empty ? '0 : head[x_cord_width_p + y_cord_width_p +: load_id_width_p];
        assign rev_dst_x_o[c*x_cord_width_p +: x_cord_width_p] =
            empty ? '0 : head[y_cord_width_p +: x_cord_width_p];
        assign rev_dst_y_o[c*y_cord_width_p +: y_cord_width_p] =
            empty ? '0 : head[0 +: y_cord_width_p];
        assign count_o[c*count_width_p +: count_width_p] = cnt_q;
    end

    logic                      any_acc;
    logic [CH_W-1:0]           low_ch;
    logic [x_cord_width_p-1:0] low_x;
    logic [y_cord_width_p-1:0] low_y;
    logic                      stray_q, stray_d;
    logic [CH_W-1:0]           first_ch_q, first_ch_d;
    logic [x_cord_width_p-1:0] first_x_q, first_x_d;
    logic [y_cord_width_p-1:0] first_y_q, first_y_d;

    assign any_acc = |acc;

    // Pick the lowest-index accepting channel (descending scan, last hit wins).
    always_comb begin
        low_ch = '0;
        low_x  = '0;
        low_y  = '0;
        for (int i = num_ch_p - 1; i >= 0; i--) begin
            if (acc[i]) begin
                low_ch = CH_W'(i);
                low_x  = fwd_src_x_i[i*x_cord_width_p +: x_cord_width_p];
                low_y  = fwd_src_y_i[i*y_cord_width_p +: y_cord_width_p];
            end
        end
    end

    // First-offender capture: clear zeroes it, but an accept in the same cycle re-arms it.
    always_comb begin
        stray_d    = stray_q;
        first_ch_d = first_ch_q;
        first_x_d  = first_x_q;
        first_y_d  = first_y_q;
        if (clear_i) begin
            stray_d    = 1'b0;
            first_ch_d = '0;
            first_x_d  = '0;
            first_y_d  = '0;
        end
        if ((!stray_q || clear_i) && any_acc) begin
            stray_d    = 1'b1;
            first_ch_d = low_ch;
            first_x_d  = low_x;
            first_y_d  = low_y;
        end
    end

    // Capture registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stray_q    <= 1'b0;
            first_ch_q <= '0;
            first_x_q  <= '0;
            first_y_q  <= '0;
        end else begin
            stray_q    <= stray_d;
            first_ch_q <= first_ch_d;
            first_x_q  <= first_x_d;
            first_y_q  <= first_y_d;
        end
    end

    assign stray_o    = stray_q;
    assign first_ch_o = first_ch_q;
    assign first_x_o  = first_x_q;
    assign first_y_o  = first_y_q;

endmodule

// File: tb/tb_bsg_manycore_link_sif_trap.sv
// Bench for the link_sif trap: directed vector table, hand-written corner
// sequences and a randomized run, all against a queue-based reference model.
module tb_bsg_manycore_link_sif_trap;

    localparam int NCH = 4;
    localparam int XW  = 4;
    localparam int YW  = 3;
    localparam int IDW = 5;
    localparam int DW  = 32;
    localparam int ELS = 2;
    localparam int CW  = 4;
    localparam logic [31:0] PAT = 32'hDEAD_BEEF;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                respond_en = 1'b0;
    logic                clear = 1'b0;
    logic [NCH-1:0]      fwd_v = '0;
    logic [NCH*2-1:0]    fwd_op = '0;
    logic [NCH*XW-1:0]   fwd_x = '0;
    logic [NCH*YW-1:0]   fwd_y = '0;
    logic [NCH*IDW-1:0]  fwd_id = '0;
    logic [NCH-1:0]      fwd_ready;
    logic [NCH-1:0]      rev_v;
    logic [NCH-1:0]      rev_type;
    logic [NCH*DW-1:0]   rev_data;
    logic [NCH*IDW-1:0]  rev_id;
    logic [NCH*XW-1:0]   rev_x;
    logic [NCH*YW-1:0]   rev_y;
    logic [NCH-1:0]      rev_ready = '0;
    logic [NCH*CW-1:0]   count;
    logic                stray;
    logic [1:0]          first_ch;
    logic [XW-1:0]       first_x;
    logic [YW-1:0]       first_y;

    bsg_manycore_link_sif_trap #(
        .num_ch_p(NCH), .x_cord_width_p(XW), .y_cord_width_p(YW),
        .load_id_width_p(IDW), .data_width_p(DW), .els_p(ELS),
        .count_width_p(CW), .load_pattern_p(PAT)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .respond_en_i(respond_en), .clear_i(clear),
        .fwd_v_i(fwd_v), .fwd_op_i(fwd_op), .fwd_src_x_i(fwd_x), .fwd_src_y_i(fwd_y),
        .fwd_load_id_i(fwd_id), .fwd_ready_o(fwd_ready),
        .rev_v_o(rev_v), .rev_type_o(rev_type), .rev_data_o(rev_data),
        .rev_load_id_o(rev_id), .rev_dst_x_o(rev_x), .rev_dst_y_o(rev_y),
        .rev_ready_i(rev_ready), .count_o(count), .stray_o(stray),
        .first_ch_o(first_ch), .first_x_o(first_x), .first_y_o(first_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        t;
        logic [31:0] d;
        logic [4:0]  id;
        logic [3:0]  x;
        logic [2:0]  y;
    } resp_t;

    typedef struct {
        logic        en, clr;
        logic [3:0]  v;
        logic [1:0]  op;
        logic [3:0]  x;
        logic [2:0]  y;
        logic [4:0]  id;
        logic [3:0]  rr;
        logic [3:0]  e_rdy, e_rv;
        logic [15:0] e_cnt;
        logic        e_stray;
        logic [1:0]  e_first;
    } vec_t;

    resp_t       mq [NCH][$];
    int          mcnt [NCH];
    logic        mstray;
    int          mfirst;
    logic [3:0]  mfx;
    logic [2:0]  mfy;
    int          nvec = 0;
    int          nmis = 0;
    vec_t        tbl [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int en, input int clr, input int v, input int op,
                                input int x, input int y, input int id, input int rr,
                                input int erdy, input int erv, input int ecnt,
                                input int estray, input int efirst);
        vec_t m;
        m.en = en[0]; m.clr = clr[0]; m.v = v[3:0]; m.op = op[1:0];
        m.x = x[3:0]; m.y = y[2:0]; m.id = id[4:0]; m.rr = rr[3:0];
        m.e_rdy = erdy[3:0]; m.e_rv = erv[3:0]; m.e_cnt = ecnt[15:0];
        m.e_stray = estray[0]; m.e_first = efirst[1:0];
        return m;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            mcnt[c] = 0;
        end
        mstray = 1'b0; mfirst = 0; mfx = '0; mfy = '0;
    endtask

    // Compare every DUT output against the model's current state.
    task automatic model_check();
        logic [3:0] erdy, erv;
        for (int c = 0; c < NCH; c++) begin
            erdy[c] = respond_en ? (mq[c].size() < ELS) : 1'b1;
            erv[c]  = (mq[c].size() > 0);
        end
        chk("ready", 64'(fwd_ready), 64'(erdy));
        chk("rev_v", 64'(rev_v), 64'(erv));
        for (int c = 0; c < NCH; c++) begin
            if (mq[c].size() > 0) begin
                chk("rev_type", 64'(rev_type[c]), 64'(mq[c][0].t));
                chk("rev_data", 64'(rev_data[c*DW +: DW]), 64'(mq[c][0].d));
                chk("rev_id", 64'(rev_id[c*IDW +: IDW]), 64'(mq[c][0].id));
                chk("rev_x", 64'(rev_x[c*XW +: XW]), 64'(mq[c][0].x));
                chk("rev_y", 64'(rev_y[c*YW +: YW]), 64'(mq[c][0].y));
            end
            chk("count", 64'(count[c*CW +: CW]), 64'(mcnt[c]));
        end
        chk("stray", 64'(stray), 64'(mstray));
        chk("first_ch", 64'(first_ch), 64'(mfirst));
        chk("first_x", 64'(first_x), 64'(mfx));
        chk("first_y", 64'(first_y), 64'(mfy));
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_update();
        logic [3:0] acc;
        int         low;
        resp_t      r;
        low = -1;
        for (int c = 0; c < NCH; c++) begin
            acc[c] = fwd_v[c] & (respond_en ? (mq[c].size() < ELS) : 1'b1);
            if (acc[c] && low < 0) low = c;
        end
        for (int c = 0; c < NCH; c++) begin
            if (mq[c].size() > 0 && rev_ready[c]) void'(mq[c].pop_front());
            if (acc[c] && respond_en && fwd_op[2*c +: 2] != 2'd3) begin
                r.t  = (fwd_op[2*c +: 2] != 2'd1);
                r.d  = (fwd_op[2*c +: 2] == 2'd1) ? 32'd0 : PAT;
                r.id = fwd_id[c*IDW +: IDW];
                r.x  = fwd_x[c*XW +: XW];
                r.y  = fwd_y[c*YW +: YW];
                mq[c].push_back(r);
            end
            if (clear) mcnt[c] = acc[c] ? 1 : 0;
            else if (acc[c] && mcnt[c] < (1 << CW) - 1) mcnt[c]++;
        end
        if ((!mstray || clear) && low >= 0) begin
            mstray = 1'b1; mfirst = low;
            mfx = fwd_x[low*XW +: XW]; mfy = fwd_y[low*YW +: YW];
        end else if (clear) begin
            mstray = 1'b0; mfirst = 0; mfx = '0; mfy = '0;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_same(input logic en, input logic clr, input logic [3:0] v,
                              input logic [1:0] op, input logic [3:0] x, input logic [2:0] y,
                              input logic [4:0] id, input logic [3:0] rr);
        respond_en = en; clear = clr; fwd_v = v;
        fwd_op = {NCH{op}}; fwd_x = {NCH{x}}; fwd_y = {NCH{y}}; fwd_id = {NCH{id}};
        rev_ready = rr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #23 reset_n = 1'b1;
        @(posedge clk); #1;

        tbl[0]  = mk(1,0,4'b0010,0,3,2,5,4'hF, 4'hF,4'h0,16'h0000,0,0);
        tbl[1]  = mk(1,0,4'b0000,0,3,2,5,4'hF, 4'hF,4'h2,16'h0010,1,1);
        tbl[2]  = mk(1,1,4'b0000,0,0,0,0,4'hF, 4'hF,4'h0,16'h0010,1,1);
        tbl[3]  = mk(1,0,4'b0001,1,0,0,0,4'h0, 4'hF,4'h0,16'h0000,0,0);
        tbl[4]  = mk(1,0,4'b0001,1,0,0,0,4'h0, 4'hF,4'h1,16'h0001,1,0);
        tbl[5]  = mk(1,0,4'b0001,1,0,0,0,4'h0, 4'hE,4'h1,16'h0002,1,0);
        tbl[6]  = mk(1,0,4'b0001,1,0,0,0,4'h1, 4'hE,4'h1,16'h0002,1,0);
        tbl[7]  = mk(1,0,4'b0001,1,0,0,0,4'h1, 4'hF,4'h1,16'h0002,1,0);
        tbl[8]  = mk(1,0,4'b0000,1,0,0,0,4'h1, 4'hF,4'h1,16'h0003,1,0);
        tbl[9]  = mk(1,1,4'b0000,0,0,0,0,4'hF, 4'hF,4'h0,16'h0003,1,0);
        tbl[10] = mk(1,0,4'b1100,0,1,1,1,4'hF, 4'hF,4'h0,16'h0000,0,0);
        tbl[11] = mk(1,0,4'b0000,0,0,0,0,4'hF, 4'hF,4'hC,16'h1100,1,2);
        tbl[12] = mk(1,1,4'b0000,0,0,0,0,4'hF, 4'hF,4'h0,16'h1100,1,2);
        tbl[13] = mk(1,0,4'b0001,3,0,0,0,4'hF, 4'hF,4'h0,16'h0000,0,0);
        tbl[14] = mk(1,0,4'b0000,0,0,0,0,4'hF, 4'hF,4'h0,16'h0001,1,0);

        for (int i = 0; i < 15; i++) begin
            drive_same(tbl[i].en, tbl[i].clr, tbl[i].v, tbl[i].op,
                       tbl[i].x, tbl[i].y, tbl[i].id, tbl[i].rr);
            at_neg();
            chk($sformatf("tbl%0d_ready", i), 64'(fwd_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_rev_v", i), 64'(rev_v), 64'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_stray", i), 64'(stray), 64'(tbl[i].e_stray));
            chk($sformatf("tbl%0d_first", i), 64'(first_ch), 64'(tbl[i].e_first));
            if (i == 1) begin
                chk("ld_data", 64'(rev_data[DW +: DW]), 64'(32'hDEAD_BEEF));
                chk("ld_type", 64'(rev_type[1]), 64'(1));
                chk("ld_id", 64'(rev_id[IDW +: IDW]), 64'(5));
                chk("ld_dst", 64'({rev_x[XW +: XW], rev_y[YW +: YW]}), 64'({4'd3, 3'd2}));
            end
            if (i == 4) begin
                chk("st_ack", 64'({rev_type[0], rev_data[0 +: DW]}), 64'(0));
            end
            at_pos();
        end

        // Drop mode: clear with a coincident accept, then 19 more loads on ch0.
        for (int n = 1; n <= 20; n++) begin
            drive_same(1'b0, (n == 1), 4'b0001, 2'd0, 4'd2, 3'd1, 5'd3, 4'hF);
            at_neg();
            chk("drop_ready", 64'(fwd_ready), 64'(4'hF));
            chk("drop_no_rev", 64'(rev_v), 64'(0));
            if (n == 11) chk("cnt_10", 64'(count[0 +: CW]), 64'(10));
            at_pos();
        end
        drive_same(1'b0, 1'b1, 4'b0001, 2'd0, 4'd2, 3'd1, 5'd3, 4'hF);
        at_neg();
        chk("cnt_sat", 64'(count[0 +: CW]), 64'(15));
        at_pos();
        drive_same(1'b0, 1'b0, 4'b0000, 2'd0, 4'd0, 3'd0, 5'd0, 4'hF);
        at_neg();
        chk("clr_acc_cnt", 64'(count[0 +: CW]), 64'(1));
        chk("clr_acc_stray", 64'(stray), 64'(1));
        at_pos();

        // Queue two loads on ch1, then pull reset in the middle of draining them.
        for (int n = 0; n < 2; n++) begin
            drive_same(1'b1, 1'b0, 4'b0010, 2'd0, 4'd5, 3'd1, 5'd9, 4'h0);
            at_neg();
            at_pos();
        end
        drive_same(1'b1, 1'b0, 4'b0000, 2'd0, 4'd0, 3'd0, 5'd0, 4'b0010);
        at_neg();
        chk("pre_rst_rev_v", 64'(rev_v), 64'(4'b0010));
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_rev_v", 64'(rev_v), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_stray", 64'(stray), 64'(0));
        model_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        chk("post_rst_rev", 64'({rev_v, rev_type, rev_id, rev_x, rev_y}), 64'(0));
        chk("post_rst_data", 64'(rev_data[63:0]), 64'(0));
        chk("post_rst_data_hi", 64'(rev_data[127:64]), 64'(0));
        chk("post_rst_first", 64'({stray, first_ch, first_x, first_y}), 64'(0));
        @(posedge clk); #1;

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            respond_en = ($urandom_range(0, 7) != 0);
            clear      = ($urandom_range(0, 15) == 0);
            fwd_v      = 4'($urandom);
            fwd_op     = 8'($urandom);
            fwd_x      = 16'($urandom);
            fwd_y      = 12'($urandom);
            fwd_id     = 20'($urandom);
            rev_ready  = 4'($urandom) | 4'($urandom);
            at_neg();
            at_pos();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
